// File: rtl/rx_capture_mem_pkg.sv
// Shared definitions for the SPI receive capture buffer: register map,
// control/status bit positions, FSM encoding and size defaults.
package rx_capture_mem_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int DEPTH_DEF  = 128;
  localparam int ADDR_W_DEF = 7;

  localparam logic [9:0] CTRL_OFS   = 10'h000;
  localparam logic [9:0] COUNT_OFS  = 10'h004;
  localparam logic [9:0] TARGET_OFS = 10'h008;
  localparam logic [9:0] MEM_BASE   = 10'h200;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // The whole upper half of the 1 KiB window maps onto the capture memory.
  function automatic logic is_mem_addr(input logic [9:0] a);
    return (a & MEM_BASE) != 10'h000;
  endfunction

endpackage

// File: rtl/rx_capture_mem_if.sv
// APB slave bus bundle for the capture buffer; the interconnect drives the
// master side, the capture block implements the slave side.
interface rx_capture_mem_if;

  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/rx_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// Read-during-write to the same entry returns the previous contents.
module rx_capture_ram
  import rx_capture_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_reg[rd_addr];
    end
  end

endmodule

// File: rtl/rx_capture_mem.sv
// APB-programmable capture buffer: stores words from the SPI receiver until a
// programmed count is reached, then lets software read them back.
module rx_capture_mem
  import rx_capture_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  rx_capture_mem_if.slave   APB_S_0,
  output logic              RxSPIen,
  input  logic [DATA_W-1:0] data_from_SPI,
  input  logic              rx_valid
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              done_reg, done_next;
  logic              ovf_reg, ovf_next;
  logic [7:0]        target_reg;
  logic              pready_reg;
  logic [31:0]       prdata_reg;
  logic              mem_sel_reg;

  logic [9:0]        addr;
  logic              access, wr_fire, rd_fire, is_mem;
  logic              ctrl_wr, start_wr, abort_wr, target_wr;
  logic              busy;
  logic [CNT_W-1:0]  tgt_eff, count_inc;
  logic [31:0]       rd_value;
  logic              ram_wr_en, ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic              unused_apb_bits;

  assign addr     = APB_S_0.paddr[9:0];
  assign is_mem   = is_mem_addr(addr);
  assign access   = APB_S_0.psel & APB_S_0.penable & ~pready_reg;
  assign wr_fire  = access & APB_S_0.pwrite;
  assign rd_fire  = access & ~APB_S_0.pwrite;
  assign busy     = (state_reg == ST_CAPTURE);

  assign ctrl_wr   = wr_fire && (addr == CTRL_OFS);
  assign abort_wr  = ctrl_wr && APB_S_0.pwdata[CTRL_ABORT_BIT];
  assign start_wr  = ctrl_wr && APB_S_0.pwdata[CTRL_START_BIT] && !APB_S_0.pwdata[CTRL_ABORT_BIT];
  assign target_wr = wr_fire && (addr == TARGET_OFS) && !busy;

  // A zero or oversized target means "fill the whole memory".
  assign tgt_eff   = ((target_reg == 8'd0) || (int'(target_reg) > DEPTH)) ?
                     CNT_W'(DEPTH) : CNT_W'(target_reg);
  assign count_inc = count_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = done_reg;
    ovf_next   = ovf_reg;
    ram_wr_en  = 1'b0;
    case (state_reg)
      ST_CAPTURE: begin
        if (rx_valid) begin
          ram_wr_en  = 1'b1;
          count_next = count_inc;
          if (count_inc == tgt_eff) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
        // Abort overrides completion, but a coincident word is still kept.
        if (abort_wr) begin
          state_next = ST_IDLE;
          done_next  = 1'b0;
        end
      end
      default: begin
        if (start_wr) begin
          state_next = ST_CAPTURE;
          count_next = '0;
          done_next  = 1'b0;
          ovf_next   = 1'b0;
        end
        if (rx_valid) begin
          ovf_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      target_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      ovf_reg   <= ovf_next;
      if (target_wr) begin
        target_reg <= APB_S_0.pwdata[7:0];
      end
    end
  end

  always_comb begin
    rd_value = '0;
    if (!is_mem) begin
      case (addr)
        CTRL_OFS: begin
          rd_value[STAT_DONE_BIT] = done_reg;
          rd_value[STAT_BUSY_BIT] = busy;
          rd_value[STAT_OVF_BIT]  = ovf_reg;
        end
        COUNT_OFS:  rd_value = 32'(count_reg);
        TARGET_OFS: rd_value = 32'(target_reg);
        default:    rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pready_reg  <= 1'b0;
      prdata_reg  <= '0;
      mem_sel_reg <= 1'b0;
    end else begin
      pready_reg <= APB_S_0.psel & APB_S_0.penable;
      if (rd_fire) begin
        prdata_reg  <= rd_value;
        mem_sel_reg <= is_mem;
      end
    end
  end

  assign ram_rd_en = rd_fire & is_mem;

  rx_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (count_reg[ADDR_W-1:0]),
    .wr_data (data_from_SPI),
    .rd_en   (ram_rd_en),
    .rd_addr (APB_S_0.paddr[ADDR_W+1:2]),
    .rd_data (ram_rd_data)
  );

  // Memory reads come straight from the RAM output register.
  assign APB_S_0.prdata  = mem_sel_reg ? 32'(ram_rd_data) : prdata_reg;
  assign APB_S_0.pready  = pready_reg;
  assign APB_S_0.pslverr = 1'b0;
  assign RxSPIen         = busy;

  assign unused_apb_bits = ^{APB_S_0.paddr[31:10], APB_S_0.pwdata[31:8]};

endmodule

// File: tb/tb_rx_capture_mem.sv
// Self-checking bench for rx_capture_mem: APB reads are scoreboarded and
// compared when pready returns; a vector table covers the register map.
module tb_rx_capture_mem;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        RxSPIen;
  logic        rx_valid = 1'b0;
  logic [11:0] data_from_SPI = 12'h000;

  always #5 clk = ~clk;

  rx_capture_mem_if apb();

  rx_capture_mem dut (
    .clk           (clk),
    .rstn          (rstn),
    .APB_S_0       (apb),
    .RxSPIen       (RxSPIen),
    .data_from_SPI (data_from_SPI),
    .rx_valid      (rx_valid)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb_q[$];
  string       sb_name_q[$];
  logic [11:0] word_q[$];
  vec_t        vecs[13];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every pready pops one expected entry pushed by apb_xfer.
  always @(negedge clk) begin
    sb_t   e;
    string nm;
    if (rstn && apb.pready) begin
      check("pslverr", 32'(apb.pslverr), 32'h0);
      if (sb_q.size() == 0) begin
        check("spurious_pready", 32'(apb.pready), 32'h0);
      end else begin
        e  = sb_q.pop_front();
        nm = sb_name_q.pop_front();
        if (e.chk) check(nm, apb.prdata, e.exp);
      end
    end
  end

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input string name,
                          input bit rx_pulse = 1'b0, input logic [11:0] rx_word = 12'h000);
    sb_t e;
    @(negedge clk);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    e.chk = ~wr;
    e.exp = exp;
    sb_q.push_back(e);
    sb_name_q.push_back(name);
    @(negedge clk);
    apb.penable = 1'b1;
    if (rx_pulse) begin
      rx_valid      = 1'b1;
      data_from_SPI = rx_word;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check({name, "_pready_hi"}, 32'(apb.pready), 32'h1);
    $display("apb %s %s addr=0x%03h wdata=0x%0h prdata=0x%0h", name, wr ? "wr" : "rd",
             addr[9:0], wdata, apb.prdata);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(negedge clk);
    check({name, "_pready_lo"}, 32'(apb.pready), 32'h0);
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input string name);
    apb_xfer(1'b1, addr, data, 32'h0, name);
  endtask

  task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    apb_xfer(1'b0, addr, 32'h0, exp, name);
  endtask

  // Drives word_q back-to-back, checking RxSPIen before each word and after the last.
  task automatic send_words(input bit en_during, input bit en_after, input string name);
    int n;
    n = word_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_en%0d", name, i), 32'(RxSPIen), 32'(en_during));
      rx_valid      = 1'b1;
      data_from_SPI = word_q.pop_front();
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check({name, "_en_after"}, 32'(RxSPIen), 32'(en_after));
    $display("rx %s: %0d words", name, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 32'h0; apb.pwdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rxen",   32'(RxSPIen), 32'h0);
    check("rst_pready", 32'(apb.pready), 32'h0);
    check("rst_prdata", apb.prdata, 32'h0);
    check("rst_slverr", 32'(apb.pslverr), 32'h0);
    rstn = 1'b1;
    apb_rd(32'h000, 32'h0, "rst_ctrl");
    apb_rd(32'h004, 32'h0, "rst_count");
    apb_rd(32'h008, 32'h0, "rst_target");

    // Four-word capture
    apb_wr(32'h008, 32'h4, "t2_target");
    apb_wr(32'h000, 32'h1, "t2_start");
    check("t2_rxen_on", 32'(RxSPIen), 32'h1);
    word_q = '{12'h111, 12'h222, 12'h333, 12'hABC};
    send_words(1'b1, 1'b0, "t2");

    vecs[0]  = '{1'b0, 32'h000, 32'h0,   32'h1};
    vecs[1]  = '{1'b0, 32'h004, 32'h0,   32'h4};
    vecs[2]  = '{1'b0, 32'h008, 32'h0,   32'h4};
    vecs[3]  = '{1'b0, 32'h200, 32'h0,   32'h111};
    vecs[4]  = '{1'b0, 32'h204, 32'h0,   32'h222};
    vecs[5]  = '{1'b0, 32'h208, 32'h0,   32'h333};
    vecs[6]  = '{1'b0, 32'h20C, 32'h0,   32'hABC};
    vecs[7]  = '{1'b1, 32'h200, 32'hFFF, 32'h0};
    vecs[8]  = '{1'b0, 32'h200, 32'h0,   32'h111};
    vecs[9]  = '{1'b0, 32'h00C, 32'h0,   32'h0};
    vecs[10] = '{1'b0, 32'h100, 32'h0,   32'h0};
    vecs[11] = '{1'b1, 32'h00C, 32'h5A,  32'h0};
    vecs[12] = '{1'b0, 32'h008, 32'h0,   32'h4};
    for (int i = 0; i < 13; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Full 128-word capture, then overflow in DONE
    apb_wr(32'h008, 32'h0, "t3_target");
    apb_wr(32'h000, 32'h1, "t3_start");
    for (int i = 0; i < 128; i++) word_q.push_back(12'(i));
    send_words(1'b1, 1'b0, "t3");
    apb_rd(32'h004, 32'h80, "t3_count");
    apb_rd(32'h000, 32'h1,  "t3_ctrl");
    apb_rd(32'h3FC, 32'h7F, "t3_mem127");
    apb_rd(32'h27C, 32'h1F, "t3_mem31");
    word_q = '{12'hFFF};
    send_words(1'b0, 1'b0, "t3_extra");
    apb_rd(32'h000, 32'h5, "t3_ovf");
    apb_rd(32'h200, 32'h0, "t3_mem0");

    // Abort, restart, busy-protected TARGET, start ignored while busy
    apb_wr(32'h008, 32'hA, "t4_target");
    apb_wr(32'h000, 32'h1, "t4_start");
    word_q = '{12'h0A1, 12'h0A2, 12'h0A3};
    send_words(1'b1, 1'b1, "t4");
    apb_wr(32'h000, 32'h2, "t4_abort");
    check("t4_rxen_off", 32'(RxSPIen), 32'h0);
    apb_rd(32'h000, 32'h0, "t4_ctrl");
    apb_rd(32'h004, 32'h3, "t4_count");
    apb_wr(32'h000, 32'h1, "t4_restart");
    apb_rd(32'h004, 32'h0, "t4_count0");
    apb_rd(32'h000, 32'h2, "t4_busy");
    apb_wr(32'h008, 32'h5, "t4_target_busy");
    apb_rd(32'h008, 32'hA, "t4_target_kept");
    word_q = '{12'h0B1, 12'h0B2};
    send_words(1'b1, 1'b1, "t4b");
    apb_wr(32'h000, 32'h1, "t4_start_again");
    apb_rd(32'h004, 32'h2, "t4_count_kept");
    apb_wr(32'h000, 32'h3, "t4_abort_wins");
    apb_rd(32'h000, 32'h0, "t4_ctrl_idle");
    apb_rd(32'h004, 32'h2, "t4_count_idle");

    // Dropped words: IDLE, start cycle, and a word coinciding with abort
    word_q = '{12'h444};
    send_words(1'b0, 1'b0, "t5_idle");
    apb_rd(32'h000, 32'h4, "t5_ovf_idle");
    apb_rd(32'h004, 32'h2, "t5_count_idle");
    apb_xfer(1'b1, 32'h000, 32'h1, 32'h0, "t5_start_rx", 1'b1, 12'h777);
    apb_rd(32'h000, 32'h6, "t5_ctrl_start");
    apb_rd(32'h004, 32'h0, "t5_count_start");
    apb_xfer(1'b1, 32'h000, 32'h2, 32'h0, "t5_abort_rx", 1'b1, 12'h5A5);
    apb_rd(32'h000, 32'h4, "t5_ctrl_abort");
    apb_rd(32'h004, 32'h1, "t5_count_abort");
    apb_rd(32'h200, 32'h5A5, "t5_mem0");

    // Reset asserted mid-capture
    apb_wr(32'h008, 32'h8, "t6_target");
    apb_wr(32'h000, 32'h1, "t6_start");
    word_q = '{12'h0C1, 12'h0C2};
    send_words(1'b1, 1'b1, "t6");
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_rxen",   32'(RxSPIen), 32'h0);
    check("t6_rst_pready", 32'(apb.pready), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    apb_rd(32'h000, 32'h0, "t6_ctrl");
    apb_rd(32'h004, 32'h0, "t6_count");
    apb_rd(32'h008, 32'h0, "t6_target_rd");

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
